mem2serial: RTL and testbench

MEM2SERIAL -- requirements
Module: mem2serial

---
 rtl/mem2serial_pkg.sv | 18 +
 rtl/frame_ring_ptrs.sv | 66 ++++++
 rtl/mem2serial.sv | 125 ++++++++++++
 tb/tb_mem2serial.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem2serial_pkg.sv
// Shared constants and reader state encoding for the frame-ring to UART serializer.
package mem2serial_pkg;

    localparam int unsigned FRAME_BYTES = 6;
    localparam int unsigned SLOT_BITS   = 5;
    localparam int unsigned SLOT_STRIDE = 8;
    localparam int unsigned MAX_FRAMES  = 31;
    localparam int unsigned BYTE_BITS   = $clog2(SLOT_STRIDE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_FETCH,
        ST_SEND,
        ST_RETIRE
    } rd_state_e;

endpackage

// File: rtl/frame_ring_ptrs.sv
// Ring bookkeeping: write/read slot pointers, stored-frame count, commit edge
// detection and the sticky overflow flag.
module frame_ring_ptrs
    import mem2serial_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 lpc_frame_done,
    input  logic                 retire,
    input  logic                 overflow_clear,
    output logic [SLOT_BITS-1:0] wp,
    output logic [SLOT_BITS-1:0] rp,
    output logic [SLOT_BITS:0]   count,
    output logic                 overflow
);

    localparam logic [SLOT_BITS-1:0] PTR_ONE = SLOT_BITS'(1);
    localparam logic [SLOT_BITS:0]   CNT_ONE = (SLOT_BITS + 1)'(1);
    localparam logic [SLOT_BITS:0]   CNT_MAX = (SLOT_BITS + 1)'(MAX_FRAMES);

    logic                 done_q, done_d;
    logic [SLOT_BITS-1:0] wp_q, wp_d;
    logic [SLOT_BITS-1:0] rp_q, rp_d;
    logic [SLOT_BITS:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 commit, accept, drop;

    always_comb begin
        commit     = lpc_frame_done && !done_q;
        accept     = commit && (count_q < CNT_MAX);
        drop       = commit && (count_q == CNT_MAX);
        done_d     = lpc_frame_done;
        wp_d       = accept ? wp_q + PTR_ONE : wp_q;
        rp_d       = retire ? rp_q + PTR_ONE : rp_q;
        count_d    = count_q;
        // A commit landing in the retire cycle cancels out in the count.
        if (accept && !retire) begin
            count_d = count_q + CNT_ONE;
        end else if (!accept && retire) begin
            count_d = count_q - CNT_ONE;
        end
        overflow_d = drop || (overflow_q && !overflow_clear);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done_q     <= 1'b1;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q     <= done_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign wp       = wp_q;
    assign rp       = rp_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/mem2serial.sv
// Streams committed 6-byte frames from the staging RAM to a UART transmitter,
// optionally prefixed by a sync byte, with a 31-deep slot ring.
module mem2serial
    import mem2serial_pkg::*;
#(
    parameter bit         SEND_SYNC = 1'b1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       lpc_frame_done,
    output logic [4:0] write_addr,
    output logic [7:0] ram_addr,
    input  logic [7:0] ram_data,
    output logic [7:0] uart_data,
    output logic       uart_valid,
    input  logic       uart_ready,
    output logic       empty,
    output logic       overflow,
    input  logic       overflow_clear
);

    localparam logic [BYTE_BITS-1:0] FIRST_IDX = '0;
    localparam logic [BYTE_BITS-1:0] LAST_IDX  = BYTE_BITS'(FRAME_BYTES - 1);
    localparam logic [BYTE_BITS-1:0] IDX_ONE   = BYTE_BITS'(1);

    logic [SLOT_BITS-1:0] wp, rp;
    logic [SLOT_BITS:0]   count;
    logic                 retire;

    rd_state_e            state_q;
    logic [BYTE_BITS-1:0] idx_q;
    logic                 fetch_wait_q;
    logic [7:0]           ram_addr_q;
    logic [7:0]           uart_data_q;
    logic                 uart_valid_q;

    assign retire = (state_q == ST_RETIRE);

    frame_ring_ptrs u_ptrs (
        .clock          (clock),
        .reset          (reset),
        .lpc_frame_done (lpc_frame_done),
        .retire         (retire),
        .overflow_clear (overflow_clear),
        .wp             (wp),
        .rp             (rp),
        .count          (count),
        .overflow       (overflow)
    );

    // FETCH spans two cycles: address out, then capture the RAM's registered data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            fetch_wait_q <= 1'b0;
            ram_addr_q   <= '0;
            uart_data_q  <= '0;
            uart_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count != '0) begin
                        if (SEND_SYNC) begin
                            state_q <= ST_SYNC;
                        end else begin
                            state_q      <= ST_FETCH;
                            idx_q        <= FIRST_IDX;
                            fetch_wait_q <= 1'b0;
                            ram_addr_q   <= {rp, FIRST_IDX};
                        end
                    end
                end
                ST_SYNC: begin
                    if (!uart_valid_q) begin
                        uart_valid_q <= 1'b1;
                        uart_data_q  <= SYNC_BYTE;
                    end else if (uart_ready) begin
                        uart_valid_q <= 1'b0;
                        state_q      <= ST_FETCH;
                        idx_q        <= FIRST_IDX;
                        fetch_wait_q <= 1'b0;
                        ram_addr_q   <= {rp, FIRST_IDX};
                    end
                end
                ST_FETCH: begin
                    if (!fetch_wait_q) begin
                        fetch_wait_q <= 1'b1;
                    end else begin
                        uart_data_q  <= ram_data;
                        uart_valid_q <= 1'b1;
                        state_q      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (uart_ready) begin
                        uart_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_RETIRE;
                        end else begin
                            idx_q        <= idx_q + IDX_ONE;
                            state_q      <= ST_FETCH;
                            fetch_wait_q <= 1'b0;
                            ram_addr_q   <= {rp, idx_q + IDX_ONE};
                        end
                    end
                end
                ST_RETIRE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign write_addr = wp;
    assign ram_addr   = ram_addr_q;
    assign uart_data  = uart_data_q;
    assign uart_valid = uart_valid_q;
    assign empty      = (count == '0);

endmodule

// File: tb/tb_mem2serial.sv
// Randomized bench: a frame-level byte-stream model predicts every UART transfer,
// the write pointer and the overflow flag; literal checks pin the model.
module tb_mem2serial;

    logic       clock;
    logic       reset;
    logic       lpc_frame_done;
    logic [4:0] write_addr;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic [7:0] uart_data;
    logic       uart_valid;
    logic       uart_ready;
    logic       empty;
    logic       overflow;
    logic       overflow_clear;

    mem2serial #(
        .SEND_SYNC (1'b1),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .lpc_frame_done (lpc_frame_done),
        .write_addr     (write_addr),
        .ram_addr       (ram_addr),
        .ram_data       (ram_data),
        .uart_data      (uart_data),
        .uart_valid     (uart_valid),
        .uart_ready     (uart_ready),
        .empty          (empty),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Staging RAM with one-cycle read latency.
    logic [7:0] mem [256];
    always @(posedge clock) ram_data <= mem[ram_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready pattern: 0 = stalled, 1 = always ready, 2 = random.
    int rdy_mode = 0;
    initial uart_ready = 1'b0;
    always begin
        @(posedge clock);
        #1;
        case (rdy_mode)
            0:       uart_ready = 1'b0;
            1:       uart_ready = 1'b1;
            default: uart_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Behavioural model: frame-level ring occupancy and the expected byte stream.
    bit         started   = 1'b0;
    logic [4:0] wp_m      = '0;
    int         cnt_m     = 0;
    logic       ovf_m     = 1'b0;
    logic       prev_done = 1'b1;
    logic       hold_prev = 1'b0;
    logic [7:0] held_data = '0;
    int         frames_done = 0;
    logic [7:0] exp_b [$];
    bit         exp_last [$];
    logic [7:0] got [$];

    always @(negedge clock) begin
        logic commit_m, drop_m;
        logic [7:0] eb;
        bit el;
        if (started) begin
            check("write_addr", 32'(write_addr), 32'(wp_m));
            check("overflow", 32'(overflow), 32'(ovf_m));
            if (hold_prev) begin
                check("hold_valid", 32'(uart_valid), 32'd1);
                check("hold_data", 32'(uart_data), 32'(held_data));
            end
            if (reset) begin
                wp_m = '0; cnt_m = 0; ovf_m = 1'b0; prev_done = 1'b1; hold_prev = 1'b0;
                exp_b.delete(); exp_last.delete();
            end else begin
                if (uart_valid && uart_ready) begin
                    got.push_back(uart_data);
                    if (exp_b.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL extra_byte: got %0h, expected no transfer at %0t", uart_data, $time);
                    end else begin
                        eb = exp_b.pop_front();
                        el = exp_last.pop_front();
                        check("stream_byte", 32'(uart_data), 32'(eb));
                        if (el) begin
                            cnt_m--;
                            frames_done++;
                        end
                    end
                end
                commit_m  = lpc_frame_done && !prev_done;
                prev_done = lpc_frame_done;
                drop_m    = 1'b0;
                if (commit_m) begin
                    if (cnt_m < 31) begin
                        exp_b.push_back(8'hA5); exp_last.push_back(1'b0);
                        for (int i = 0; i < 6; i++) begin
                            exp_b.push_back(mem[{wp_m, 3'(i)}]);
                            exp_last.push_back(i == 5);
                        end
                        wp_m = wp_m + 5'd1;
                        cnt_m++;
                    end else begin
                        drop_m = 1'b1;
                    end
                end
                ovf_m     = drop_m || (ovf_m && !overflow_clear);
                hold_prev = uart_valid && !uart_ready;
                held_data = uart_data;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic stage(input logic [4:0] slot, input logic [47:0] bytes);
        for (int i = 0; i < 6; i++) mem[{slot, 3'(i)}] = bytes[47 - 8*i -: 8];
        mem[{slot, 3'd6}] = 8'($urandom);
        mem[{slot, 3'd7}] = 8'($urandom);
    endtask

    task automatic stage_random();
        stage(wp_m, 48'({$urandom(), $urandom()}));
    endtask

    task automatic pulse(input int hi);
        lpc_frame_done = 1'b1;
        repeat (hi) tick();
        lpc_frame_done = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_drained(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (empty === 1'b1 && exp_b.size() == 0) break;
            tick();
        end
        check(name, 32'(empty === 1'b1 && exp_b.size() == 0), 32'd1);
    endtask

    task automatic wait_got(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (got.size() >= n) break;
            tick();
        end
        check(name, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (uart_valid === 1'b1) break;
            tick();
        end
        check(name, 32'(uart_valid), 32'd1);
    endtask

    initial begin
        logic [7:0] lit [7];
        int fd, n0;
        bit seen;
        lit = '{8'hA5, 8'h01, 8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h55};
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b1; lpc_frame_done = 1'b0; overflow_clear = 1'b0;
        repeat (2) tick();
        started = 1'b1;
        check("rst_valid", 32'(uart_valid), 32'd0);
        check("rst_data", 32'(uart_data), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_write_addr", 32'(write_addr), 32'd0);
        reset = 1'b0;
        tick();

        // Single frame with literal stream and sync latency.
        rdy_mode = 1;
        got.delete();
        stage(5'd0, 48'h01FEDCBA9855);
        lpc_frame_done = 1'b1;
        tick();
        lpc_frame_done = 1'b0;
        tick();
        check("lat_n1_valid", 32'(uart_valid), 32'd0);
        tick();
        check("lat_n2_valid", 32'(uart_valid), 32'd1);
        check("lat_n2_data", 32'(uart_data), 32'hA5);
        wait_drained("single_drain", 200);
        check("single_len", 32'(got.size()), 32'd7);
        for (int i = 0; i < 7 && i < got.size(); i++) check("single_lit", 32'(got[i]), 32'(lit[i]));
        check("single_empty", 32'(empty), 32'd1);
        check("single_wa", 32'(write_addr), 32'd1);

        // Random traffic with a 10-cycle stall mid-frame.
        rdy_mode = 2;
        for (int k = 0; k < 12; k++) begin
            stage_random();
            pulse($urandom_range(1, 3));
            if (k == 4) begin
                wait_got("stall_reach", got.size() + 2, 300);
                rdy_mode = 0;
                repeat (2) tick();
                wait_valid("stall_valid", 40);
                repeat (10) tick();
                rdy_mode = 2;
            end
            repeat ($urandom_range(0, 15)) tick();
        end
        wait_drained("random_drain", 3000);

        // Fill up to slot 31, then commit in the RETIRE cycle of the slot-31 frame.
        while (wp_m != 5'd31) begin
            stage_random();
            pulse(1);
            repeat ($urandom_range(0, 5)) tick();
        end
        wait_drained("wrap_pre_drain", 4000);
        rdy_mode = 1;
        stage_random();
        pulse(1);
        fd = frames_done;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            if (frames_done != fd) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        check("wrap_last_seen", 32'(seen), 32'd1);
        stage_random();
        lpc_frame_done = 1'b1;
        tick();
        lpc_frame_done = 1'b0;
        check("wrap_wa", 32'(write_addr), 32'd1);
        check("wrap_not_empty", 32'(empty), 32'd0);
        wait_drained("wrap_drain", 200);

        // Overflow with reader stalled.
        rdy_mode = 0;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            stage_random();
            pulse(1);
        end
        check("ovf_wa", 32'(write_addr), 32'd31);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_not_empty", 32'(empty), 32'd0);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        stage_random();
        lpc_frame_done = 1'b1;
        overflow_clear = 1'b1;
        tick();
        lpc_frame_done = 1'b0;
        overflow_clear = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        tick();
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_cleared2", 32'(overflow), 32'd0);
        rdy_mode = 1;
        wait_drained("ovf_drain", 2000);
        check("ovf_drain_wa", 32'(write_addr), 32'd31);

        // Frame-done level held high across reset release is not a commit.
        rdy_mode = 1;
        lpc_frame_done = 1'b1;
        do_reset();
        repeat (20) tick();
        check("rsthigh_empty", 32'(empty), 32'd1);
        check("rsthigh_valid", 32'(uart_valid), 32'd0);
        check("rsthigh_wa", 32'(write_addr), 32'd0);
        lpc_frame_done = 1'b0;
        tick();

        // Reset while byte 3 is offered.
        stage_random();
        pulse(1);
        n0 = got.size();
        wait_got("midrst_reach", n0 + 4, 200);
        rdy_mode = 0;
        repeat (2) tick();
        wait_valid("midrst_valid_before", 20);
        reset = 1'b1;
        tick();
        check("midrst_valid", 32'(uart_valid), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        reset = 1'b0;
        tick();
        rdy_mode = 1;
        stage_random();
        pulse(1);
        wait_drained("recover_drain", 200);
        check("recover_wa", 32'(write_addr), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
